// File: rtl/adder_sweep_ctrl_pkg.sv
// Shared definitions for the adder sweep controller: state encoding and default sizes.
// No logic; pure constants and a width helper.
// Not applicable: no handshake.
package adder_sweep_ctrl_pkg;

  // Default operand width and per-pair hold time
  localparam int W_DEF           = 2;
  localparam int HOLD_CYCLES_DEF = 10;

  // Controller states; encodings are shared with the adder bench
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_sweep_ctrl_if.sv
// Bundle between the sweep controller and the adder / test harness.
// No latency of its own; wires only.
// No backpressure: the controller paces the adder by holding operands.
interface adder_sweep_ctrl_if
  import adder_sweep_ctrl_pkg::*;
#(
  parameter int W = W_DEF
);

  logic             start;
  logic [W-1:0]     a_out;
  logic [W-1:0]     b_out;
  logic [W-1:0]     s_in;
  logic             cout_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [2*W:0]     err_count;
  logic [2*W-1:0]   first_fail;
  logic [2*W-1:0]   vec_idx;

  // Controller side
  modport master (
    input  start, s_in, cout_in,
    output a_out, b_out, busy, done, err, err_count, first_fail, vec_idx
  );

  // Adder / harness side
  modport slave (
    output start, s_in, cout_in,
    input  a_out, b_out, busy, done, err, err_count, first_fail, vec_idx
  );

endinterface

// File: rtl/adder_sweep_ctrl_hold_timer.sv
// Hold timer: counts 0..HOLD_CYCLES-1 while enabled, tc high on the last count.
// Count advances one per enabled cycle; tc is a decode of the count register.
// No backpressure; clr overrides en.
module hold_timer
  import adder_sweep_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int              CW     = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0]   TC_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Terminal count decode
  always_comb begin
    tc = (cnt_q == TC_VAL);
  end

  // Next count: clear wins, otherwise wrap at terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adder_sweep_ctrl.sv
// Exhaustive adder self-test: drives every {a,b} pair, holds it HOLD_CYCLES, checks {cout,s}.
// done pulses 2^(2W)*HOLD_CYCLES cycles after the accepted start edge.
// No backpressure; start is ignored unless idle.
module adder_sweep_ctrl
  import adder_sweep_ctrl_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  adder_sweep_ctrl_if.master bus
);

  state_t           state_q, state_d;
  logic [2*W-1:0]   vec_idx_q, vec_idx_d;
  logic             err_q, err_d;
  logic [2*W:0]     err_count_q, err_count_d;
  logic [2*W-1:0]   first_fail_q, first_fail_d;

  logic             tc;
  logic             start_acc;
  logic             check_vld;
  logic             last_pair;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W:0]       exp_sum;
  logic [W:0]       obs_sum;

  // Timer runs only while driving; held at zero otherwise so each sweep starts aligned
  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_DRIVE),
    .en  (state_q == ST_DRIVE),
    .tc  (tc)
  );

  // Decode the current pair and compare the adder result at full W+1 width
  always_comb begin
    op_a      = vec_idx_q[2*W-1:W];
    op_b      = vec_idx_q[W-1:0];
    exp_sum   = {1'b0, op_a} + {1'b0, op_b};
    obs_sum   = {bus.cout_in, bus.s_in};
    start_acc = (state_q == ST_IDLE) && bus.start;
    check_vld = (state_q == ST_DRIVE) && tc;
    last_pair = (vec_idx_q == '1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_DRIVE;
      ST_DRIVE: if (check_vld && last_pair) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; operands forced to zero whenever not driving
  always_comb begin
    bus.busy  = (state_q == ST_DRIVE);
    bus.done  = (state_q == ST_DONE);
    bus.a_out = (state_q == ST_DRIVE) ? op_a : '0;
    bus.b_out = (state_q == ST_DRIVE) ? op_b : '0;
    bus.vec_idx    = vec_idx_q;
    bus.err        = err_q;
    bus.err_count  = err_count_q;
    bus.first_fail = first_fail_q;
  end

  // Sweep index and result bookkeeping; start clears, each check may record a failure
  always_comb begin
    vec_idx_d    = vec_idx_q;
    err_d        = err_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    if (start_acc) begin
      vec_idx_d    = '0;
      err_d        = 1'b0;
      err_count_d  = '0;
      first_fail_d = '0;
    end else if (check_vld) begin
      if (obs_sum != exp_sum) begin
        err_d       = 1'b1;
        err_count_d = err_count_q + 1'b1;
        if (!err_q) begin
          first_fail_d = vec_idx_q;
        end
      end
      // Wraps to zero after the last pair
      vec_idx_d = vec_idx_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_idx_q    <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
    end else begin
      vec_idx_q    <= vec_idx_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
    end
  end

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Bench for adder_sweep_ctrl with W=2, HOLD_CYCLES=3 and a switchable adder fault model.
// Sweep timing and final status are predicted from simple arithmetic over all pairs.
// Inputs are driven and outputs sampled on the falling edge.
module tb_adder_sweep_ctrl;

  localparam int W     = 2;
  localparam int HOLD  = 3;
  localparam int NPAIR = 16;
  localparam int SWEEP = NPAIR * HOLD;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   fault_mode;
  logic [15:0] fault_set;

  adder_sweep_ctrl_if #(.W(W)) bus ();

  adder_sweep_ctrl #(
    .W           (W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test: 0 good, 1 cout stuck 0, 2 s[0] stuck 1, 3 off-by-one on selected pairs
  function automatic logic [2:0] adder_model(input int mode, input logic [1:0] a,
                                             input logic [1:0] b, input logic [15:0] fs);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (mode)
      1: s[2] = 1'b0;
      2: s[0] = 1'b1;
      3: if (fs[{a, b}]) s = s + 3'd1;
      default: ;
    endcase
    return s;
  endfunction

  always_comb begin
    {bus.cout_in, bus.s_in} = adder_model(fault_mode, bus.a_out, bus.b_out, fault_set);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk every pair, count results that differ from the true sum
  task automatic ref_sweep(input int mode, input logic [15:0] fs,
                           output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (int'(adder_model(mode, 2'(a), 2'(b), fs)) != a + b) begin
          if (cnt == 0) first = a * 4 + b;
          cnt++;
        end
      end
    end
  endtask

  // One full sweep; start is re-pulsed during cycles rep1/rep2 and optionally in the DONE cycle
  task automatic run_sweep(input int mode, input logic [15:0] fs,
                           input int rep1, input int rep2, input bit rep_done);
    int exp_cnt;
    int exp_first;
    int idx;
    fault_mode = mode;
    fault_set  = fs;
    ref_sweep(mode, fs, exp_cnt, exp_first);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int k = 0; k <= SWEEP + 1; k++) begin
      idx = k / HOLD;
      if (k == 0) begin
        chk("clr_err", 32'(bus.err), 0);
        chk("clr_err_count", 32'(bus.err_count), 0);
        chk("clr_first_fail", 32'(bus.first_fail), 0);
      end
      if (k < SWEEP) begin
        chk("busy", 32'(bus.busy), 1);
        chk("done_early", 32'(bus.done), 0);
        chk("vec_idx", 32'(bus.vec_idx), idx);
        chk("a_out", 32'(bus.a_out), idx / 4);
        chk("b_out", 32'(bus.b_out), idx % 4);
      end else if (k == SWEEP) begin
        chk("done", 32'(bus.done), 1);
        chk("busy_done", 32'(bus.busy), 0);
        chk("a_out_end", 32'(bus.a_out), 0);
        chk("b_out_end", 32'(bus.b_out), 0);
        chk("vec_idx_end", 32'(bus.vec_idx), 0);
        chk("err", 32'(bus.err), (exp_cnt != 0) ? 1 : 0);
        chk("err_count", 32'(bus.err_count), exp_cnt);
        chk("first_fail", 32'(bus.first_fail), exp_first);
      end else begin
        chk("done_once", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("err_count_hold", 32'(bus.err_count), exp_cnt);
      end
      bus.start = (k == rep1) || (k == rep2) || (rep_done && k == SWEEP);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  // Reset at cycle 20 of a failing sweep: everything returns to zero and no done follows
  task automatic reset_mid_sweep();
    fault_mode = 2;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_err_count", 32'(bus.err_count), 0);
    chk("rst_first_fail", 32'(bus.first_fail), 0);
    chk("rst_vec_idx", 32'(bus.vec_idx), 0);
    chk("rst_a_out", 32'(bus.a_out), 0);
    chk("rst_b_out", 32'(bus.b_out), 0);
    for (int k = 0; k < SWEEP + 10; k++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(bus.done), 0);
      chk("rst_stay_idle", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    fault_mode = 0;
    fault_set  = '0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("init_busy", 32'(bus.busy), 0);
    chk("init_done", 32'(bus.done), 0);
    chk("init_err", 32'(bus.err), 0);
    chk("init_err_count", 32'(bus.err_count), 0);
    chk("init_first_fail", 32'(bus.first_fail), 0);
    chk("init_vec_idx", 32'(bus.vec_idx), 0);
    chk("init_a_out", 32'(bus.a_out), 0);
    chk("init_b_out", 32'(bus.b_out), 0);

    run_sweep(0, 16'h0, -1, -1, 1'b0);
    run_sweep(1, 16'h0, -1, -1, 1'b0);
    run_sweep(2, 16'h0, -1, -1, 1'b0);

    reset_mid_sweep();
    run_sweep(0, 16'h0, -1, -1, 1'b0);

    // Simultaneous start and reset: reset wins
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", 32'(bus.busy), 0);
    @(negedge clk);
    chk("rst_start_idle", 32'(bus.busy), 0);

    run_sweep(1, 16'h0, 5, 30, 1'b1);

    for (int r = 0; r < 4; r++) begin
      run_sweep(3, 16'($urandom), int'($urandom_range(1, SWEEP - 2)),
                int'($urandom_range(1, SWEEP - 2)), 1'($urandom_range(0, 1)));
    end
    run_sweep(0, 16'h0, int'($urandom_range(1, SWEEP - 2)), -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
